// File: rtl/nf_id_imm_ctrl_pkg.sv
// Shared CPU decode package: immediate selector constants, RV32 opcodes and
// the FSM state encoding used by nf_id_imm_ctrl.
package nf_id_imm_ctrl_pkg;

    localparam logic [1:0] I_SEL = 2'b00;
    localparam logic [1:0] U_SEL = 2'b01;
    localparam logic [1:0] B_SEL = 2'b10;
    localparam logic [1:0] S_SEL = 2'b11;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } id_state_t;

endpackage

// File: rtl/nf_sign_ex.sv
// Immediate extender: picks the extracted field for the selector and widens it
// to 32 bits (sign-extend I/B/S, zero-extend U); forced to zero when no_imm.
module nf_sign_ex
    import nf_id_imm_ctrl_pkg::*;
(
    input  logic [1:0]  i_sel,
    input  logic        i_no_imm,
    input  logic [11:0] i_fld_i,
    input  logic [19:0] i_fld_u,
    input  logic [11:0] i_fld_b,
    input  logic [11:0] i_fld_s,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm = '0;
        if (!i_no_imm) begin
            case (i_sel)
                I_SEL:   o_imm = {{20{i_fld_i[11]}}, i_fld_i};
                U_SEL:   o_imm = {12'h000, i_fld_u};
                B_SEL:   o_imm = {{20{i_fld_b[11]}}, i_fld_b};
                S_SEL:   o_imm = {{20{i_fld_s[11]}}, i_fld_s};
                default: o_imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/nf_id_imm_ctrl.sv
// Immediate decode stage with a one-entry register, or a two-entry skid buffer
// with registered ready when NF_ID_SKID_EN is defined.
//
// state    | meaning
// ST_EMPTY | no entry held, output invalid
// ST_ONE   | head entry valid
// ST_TWO   | head and skid entries valid, input stalled (skid build only)
module nf_id_imm_ctrl
    import nf_id_imm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        instr_vld_i,
    output logic        instr_rdy_o,
    input  logic        flush_i,
    output logic [31:0] imm_ex_o,
    output logic [1:0]  imm_src_o,
    output logic        no_imm_o,
    output logic        out_vld_o,
    input  logic        out_rdy_i
);

    id_state_t   r_state;
    logic        r_out_vld;
    logic [31:0] r_imm;
    logic [1:0]  r_src;
    logic        r_no_imm;

    logic [1:0]  w_sel;
    logic        w_no_imm;
    logic [31:0] w_imm;
    logic        w_in;
    logic        w_out;

    always_comb begin
        w_sel    = I_SEL;
        w_no_imm = 1'b0;
        case (instr_i[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: w_sel = I_SEL;
            OPC_LUI:                        w_sel = U_SEL;
            OPC_BRANCH:                     w_sel = B_SEL;
            OPC_STORE:                      w_sel = S_SEL;
            default:                        w_no_imm = 1'b1;
        endcase
    end

    nf_sign_ex u_sign_ex (
        .i_sel    (w_sel),
        .i_no_imm (w_no_imm),
        .i_fld_i  (instr_i[31:20]),
        .i_fld_u  (instr_i[31:12]),
        .i_fld_b  ({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]}),
        .i_fld_s  ({instr_i[31:25], instr_i[11:7]}),
        .o_imm    (w_imm)
    );

`ifdef NF_ID_SKID_EN
    logic        r_rdy;
    logic [31:0] r_skid_imm;
    logic [1:0]  r_skid_src;
    logic        r_skid_no_imm;

    // r_rdy tracks "next state is not TWO"; only rst gates it combinationally
    assign instr_rdy_o = r_rdy && !rst;
`else
    assign instr_rdy_o = !rst && (!r_out_vld || out_rdy_i);
`endif

    assign w_in  = instr_vld_i && instr_rdy_o;
    assign w_out = r_out_vld && out_rdy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_out_vld <= 1'b0;
            r_imm     <= '0;
            r_src     <= I_SEL;
            r_no_imm  <= 1'b0;
`ifdef NF_ID_SKID_EN
            r_rdy         <= 1'b1;
            r_skid_imm    <= '0;
            r_skid_src    <= I_SEL;
            r_skid_no_imm <= 1'b0;
`endif
        end else if (flush_i) begin
            // Head payload is left alone so the outputs hold while invalid
            r_state   <= ST_EMPTY;
            r_out_vld <= 1'b0;
`ifdef NF_ID_SKID_EN
            r_rdy     <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in) begin
                        r_imm     <= w_imm;
                        r_src     <= w_sel;
                        r_no_imm  <= w_no_imm;
                        r_state   <= ST_ONE;
                        r_out_vld <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in && w_out) begin
                        r_imm    <= w_imm;
                        r_src    <= w_sel;
                        r_no_imm <= w_no_imm;
`ifdef NF_ID_SKID_EN
                    end else if (w_in) begin
                        r_skid_imm    <= w_imm;
                        r_skid_src    <= w_sel;
                        r_skid_no_imm <= w_no_imm;
                        r_state       <= ST_TWO;
                        r_rdy         <= 1'b0;
`endif
                    end else if (w_out) begin
                        r_state   <= ST_EMPTY;
                        r_out_vld <= 1'b0;
                    end
                end
`ifdef NF_ID_SKID_EN
                ST_TWO: begin
                    if (w_out) begin
                        r_imm    <= r_skid_imm;
                        r_src    <= r_skid_src;
                        r_no_imm <= r_skid_no_imm;
                        r_state  <= ST_ONE;
                        r_rdy    <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state   <= ST_EMPTY;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end

    assign out_vld_o = r_out_vld;
    assign imm_ex_o  = r_imm;
    assign imm_src_o = r_src;
    assign no_imm_o  = r_no_imm;

endmodule

// File: tb/tb_nf_id_imm_ctrl.sv
// Directed bench for nf_id_imm_ctrl: decode vector table plus backpressure,
// flush and mid-stream reset sequences; adapts to NF_ID_SKID_EN.
module tb_nf_id_imm_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr_i;
    logic        instr_vld_i;
    logic        instr_rdy_o;
    logic        flush_i;
    logic [31:0] imm_ex_o;
    logic [1:0]  imm_src_o;
    logic        no_imm_o;
    logic        out_vld_o;
    logic        out_rdy_i;

    nf_id_imm_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_i     (instr_i),
        .instr_vld_i (instr_vld_i),
        .instr_rdy_o (instr_rdy_o),
        .flush_i     (flush_i),
        .imm_ex_o    (imm_ex_o),
        .imm_src_o   (imm_src_o),
        .no_imm_o    (no_imm_o),
        .out_vld_o   (out_vld_o),
        .out_rdy_i   (out_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [1:0]  src;
        logic        no_imm;
    } vec_t;

    vec_t tv[12];
    int   n_vec = 0;
    int   n_err = 0;

`ifdef NF_ID_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_instr[4];
    int          acc;
    int          got;
    logic        fire_in;
    logic        fire_out;
    logic        full_seen;

    initial begin
        tv[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 2'b00, 1'b0};
        tv[1]  = '{32'h123450B7, 32'h00012345, 2'b01, 1'b0};
        tv[2]  = '{32'hFE000EE3, 32'hFFFFFFFE, 2'b10, 1'b0};
        tv[3]  = '{32'h0020A423, 32'h00000008, 2'b11, 1'b0};
        tv[4]  = '{32'h002081B3, 32'h00000000, 2'b00, 1'b1};
        tv[5]  = '{32'h800000E7, 32'hFFFFF800, 2'b00, 1'b0};
        tv[6]  = '{32'h7FF02083, 32'h000007FF, 2'b00, 1'b0};
        tv[7]  = '{32'hFFFFF037, 32'h000FFFFF, 2'b01, 1'b0};
        tv[8]  = '{32'h7E000FA3, 32'h000007FF, 2'b11, 1'b0};
        tv[9]  = '{32'h0000006F, 32'h00000000, 2'b00, 1'b1};
        tv[10] = '{32'h00000463, 32'h00000004, 2'b10, 1'b0};
        tv[11] = '{32'hFE000023, 32'hFFFFFFE0, 2'b11, 1'b0};

        bp_instr[0] = 32'h00100093;
        bp_instr[1] = 32'h00200093;
        bp_instr[2] = 32'h00300093;
        bp_instr[3] = 32'h00400093;

        // Reset with a valid input presented: must be refused
        rst = 1'b1; flush_i = 1'b0; instr_vld_i = 1'b1;
        instr_i = 32'h00100093; out_rdy_i = 1'b1;
        tick;
        tick;
        chk("rdy_in_reset", 32'(instr_rdy_o), 32'd0);
        tick;
        rst = 1'b0; instr_vld_i = 1'b0;
        tick;
        chk("rst_out_vld", 32'(out_vld_o), 32'd0);
        chk("rst_imm",     imm_ex_o, 32'h0);
        chk("rst_src",     32'(imm_src_o), 32'd0);
        chk("rst_no_imm",  32'(no_imm_o), 32'd0);
        chk("rst_rdy",     32'(instr_rdy_o), 32'd1);

        // Back-to-back decode table, sink always ready
        for (int i = 0; i < 12; i++) begin
            instr_i = tv[i].instr; instr_vld_i = 1'b1; out_rdy_i = 1'b1;
            tick;
            chk($sformatf("v%0d_vld", i),    32'(out_vld_o), 32'd1);
            chk($sformatf("v%0d_imm", i),    imm_ex_o, tv[i].imm);
            chk($sformatf("v%0d_src", i),    32'(imm_src_o), 32'(tv[i].src));
            chk($sformatf("v%0d_no_imm", i), 32'(no_imm_o), 32'(tv[i].no_imm));
        end
        instr_vld_i = 1'b0;
        tick;
        chk("hold_vld", 32'(out_vld_o), 32'd0);
        chk("hold_imm", imm_ex_o, tv[11].imm);
        chk("hold_src", 32'(imm_src_o), 32'(tv[11].src));

        // Four-instruction stream, sink stalled for three cycles
        acc = 0; got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            out_rdy_i   = (c >= 3);
            instr_vld_i = (acc < 4);
            instr_i     = bp_instr[(acc < 4) ? acc : 3];
            @(negedge clk);
            fire_in  = instr_vld_i && instr_rdy_o;
            fire_out = out_vld_o && out_rdy_i;
            if (fire_out) begin
                chk($sformatf("bp_out%0d", got), imm_ex_o, 32'(got + 1));
                got++;
            end
            @(posedge clk);
            #1;
            if (fire_in) acc++;
            if (c == 2) chk("bp_accepted_stalled", 32'(acc), 32'(EXP_ACC));
        end
        chk("bp_all_out", 32'(got), 32'd4);
        instr_vld_i = 1'b0; out_rdy_i = 1'b1;
        tick;
        chk("bp_drained", 32'(out_vld_o), 32'd0);

        // Fill until input stalls, then flush with an input offered
        out_rdy_i = 1'b0; full_seen = 1'b0;
        for (int c = 0; c < 8 && !full_seen; c++) begin
            instr_vld_i = 1'b1; instr_i = 32'h01100093;
            @(negedge clk);
            if (!instr_rdy_o) full_seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("flush_fill_stalled", 32'(full_seen), 32'd1);
        flush_i = 1'b1; instr_i = 32'h03300093; out_rdy_i = 1'b1;
        tick;
        flush_i = 1'b0; instr_vld_i = 1'b0; out_rdy_i = 1'b0;
        chk("flush_out_vld", 32'(out_vld_o), 32'd0);
        chk("flush_rdy",     32'(instr_rdy_o), 32'd1);
        instr_i = 32'h0AAAA037; instr_vld_i = 1'b1; out_rdy_i = 1'b1;
        tick;
        instr_vld_i = 1'b0;
        chk("post_flush_vld", 32'(out_vld_o), 32'd1);
        chk("post_flush_imm", imm_ex_o, 32'h0000AAAA);
        chk("post_flush_src", 32'(imm_src_o), 32'd1);
        tick;
        chk("post_flush_empty", 32'(out_vld_o), 32'd0);

        // Reset while an entry is held
        instr_i = 32'h00500093; instr_vld_i = 1'b1; out_rdy_i = 1'b0;
        tick;
        chk("mid_rst_held", 32'(out_vld_o), 32'd1);
        instr_vld_i = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_vld", 32'(out_vld_o), 32'd0);
        chk("mid_rst_imm", imm_ex_o, 32'h0);
        out_rdy_i = 1'b1;
        tick;
        chk("mid_rst_stays_empty", 32'(out_vld_o), 32'd0);
        chk("mid_rst_rdy", 32'(instr_rdy_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nf_id_imm_ctrl.md
NF_ID_IMM_CTRL -- requirements
Module: nf_id_imm_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 instr_i  input  32  fetched RV32 instruction word.
REQ-005 instr_vld_i  input  1  instr_i is valid.
REQ-006 instr_rdy_o  output  1  block accepts instr_i this cycle.
REQ-007 flush_i  input  1  discard all held and incoming entries.
REQ-008 imm_ex_o  output  32  extended immediate of the head entry.
REQ-009 imm_src_o  output  2  immediate selector used for the head entry.
REQ-010 no_imm_o  output  1  head instruction carries no immediate.
REQ-011 out_vld_o  output  1  head entry valid.
REQ-012 out_rdy_i  input  1  downstream consumes the head entry this cycle.

Function
REQ-013 Transfer semantics: an input transfer occurs when instr_vld_i && instr_rdy_o; an output transfer occurs when out_vld_o && out_rdy_i.
REQ-014 Opcode instr_i[6:0] to selector mapping: 0010011, 0000011 and 1100111 map to I_SEL; 0110111 maps to U_SEL; 1100011 maps to B_SEL; 0100011 maps to S_SEL; every other opcode maps to I_SEL with no_imm=1 and imm_ex=0.
REQ-015 Field extraction: I = instr[31:20]; U = instr[31:12]; B = {instr[31],instr[7],instr[30:25],instr[11:8]} (halfword offset); S = {instr[31:25],instr[11:7]}.
REQ-016 Extension: I, B and S SHALL be sign-extended from bit 11 to 32 bits; U SHALL be zero-extended from 20 bits (value in bits [19:0]).
REQ-017 Decode and extension SHALL be computed at input acceptance and registered; out_vld_o SHALL rise the cycle after the accepting edge (latency 1).
REQ-018 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-019 Simultaneous input and output transfers in the same cycle SHALL keep occupancy unchanged.
REQ-020 flush_i SHALL have priority over both transfers: the next cycle all entries are invalid and any input accepted in the flush cycle is dropped.
REQ-021 FSM states are EMPTY, ONE and TWO; TWO is reachable only when NF_ID_SKID_EN is defined.
REQ-022 While out_vld_o=0, imm_ex_o, imm_src_o and no_imm_o SHALL hold their last values.

Reset
REQ-023 While rst=1, instr_rdy_o SHALL be 0 and accepted transfers SHALL be ignored.
REQ-024 On the cycle after rst deasserts: out_vld_o=0, imm_ex_o=32'h0, imm_src_o=I_SEL, no_imm_o=0, FSM in EMPTY, instr_rdy_o=1.
REQ-025 A reset asserted mid-transfer SHALL discard all entries exactly as flush_i does.

Configuration
REQ-026 Macro NF_ID_SKID_EN defined: the block SHALL provide a 2-entry skid buffer with a registered instr_rdy_o, equal to not in TWO, and no combinational path from out_rdy_i to instr_rdy_o.
REQ-027 Macro NF_ID_SKID_EN undefined: the block SHALL provide a single entry with instr_rdy_o = !out_vld_o || out_rdy_i (combinational).

Structure
REQ-028 The shared CPU package SHALL hold the selector constants I_SEL=2'b00, U_SEL=2'b01, B_SEL=2'b10 and S_SEL=2'b11, the opcode constants, and the FSM state enum.
REQ-029 The block SHALL instantiate one nf_sign_ex for extension, driven by the extracted fields and the decoded selector.

Verification
REQ-030 ADDI 32'hFFF00093, sink ready -> next cycle out_vld=1, imm_ex=32'hFFFFFFFF, imm_src=00, no_imm=0.
REQ-031 LUI 32'h123450B7 -> imm_ex=32'h00012345, imm_src=01.
REQ-032 BEQ 32'hFE000EE3 (offset -4) -> imm_ex=32'hFFFFFFFE, imm_src=10; SW 32'h0020A423 -> imm_ex=32'h00000008, imm_src=11.
REQ-033 ADD 32'h002081B3 -> no_imm=1, imm_ex=32'h0, imm_src=00.
REQ-034 Four-instruction stream with out_rdy_i=0 for 3 cycles -> skid build accepts 2 then instr_rdy_o=0; non-skid build accepts 1; in both builds, after release all 4 emerge in order with none lost.
REQ-035 flush_i asserted with two entries held and an input accepted in the same cycle -> next cycle out_vld=0, instr_rdy_o=1, and the flushed instructions never appear at the output.
